// File: rtl/axi_excl_rr_arbiter.sv
// Round-robin arbiter for a shared AXI AW/AR request port.
// An exclusive-access lock pins the port to one master until its release arrives or the lock times out.
module axi_excl_rr_arbiter #(
    parameter int N_MASTER     = 4,
    parameter int AUX_WIDTH    = 32,
    parameter int ID_WIDTH     = 4,
    parameter int LOCK_TIMEOUT = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTER-1:0]           req_i,
    input  logic [N_MASTER-1:0]           excl_i,
    input  logic [N_MASTER*AUX_WIDTH-1:0] aux_i,
    input  logic [N_MASTER*ID_WIDTH-1:0]  id_i,
    output logic [N_MASTER-1:0]           gnt_o,
    output logic                          req_o,
    output logic [AUX_WIDTH-1:0]          aux_o,
    output logic [ID_WIDTH-1:0]           id_o,
    input  logic                          gnt_i,
    input  logic                          release_i,
    input  logic [ID_WIDTH-1:0]           release_id_i,
    output logic                          locked_o,
    output logic [$clog2(N_MASTER)-1:0]   lock_owner_o,
    output logic                          timeout_o
);

    localparam int PW = $clog2(N_MASTER);
    localparam int TW = $clog2(LOCK_TIMEOUT);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]          fsm;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       owner;
    logic [ID_WIDTH-1:0] owner_id;
    logic [TW-1:0]       tcnt;

    logic                win_valid;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       sel_idx;
    logic [PW-1:0]       rr_next;
    logic                hs;
    logic                rel_match;
    logic                tmo_hit;

    logic [AUX_WIDTH-1:0] aux_arr [N_MASTER];
    logic [ID_WIDTH-1:0]  id_arr  [N_MASTER];

    for (genvar g = 0; g < N_MASTER; g++) begin : g_unpack
        assign aux_arr[g] = aux_i[g*AUX_WIDTH +: AUX_WIDTH];
        assign id_arr[g]  = id_i[g*ID_WIDTH +: ID_WIDTH];
    end

    // Scan starts at rr_ptr and wraps explicitly, so N_MASTER need not be a power of two.
    always_comb begin
        int idx;
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        if (fsm == LOCKED) begin
            if (req_i[owner]) begin
                win_valid = 1'b1;
                win_idx   = owner;
            end
        end else begin
            for (int i = 0; i < N_MASTER; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= N_MASTER) idx = idx - N_MASTER;
                if (!win_valid && req_i[idx]) begin
                    win_valid = 1'b1;
                    win_idx   = PW'(idx);
                end
            end
        end
    end

    assign sel_idx = win_valid ? win_idx : rr_ptr;
    assign req_o   = win_valid;
    assign aux_o   = aux_arr[sel_idx];
    assign id_o    = id_arr[sel_idx];

    always_comb begin
        gnt_o = '0;
        if (win_valid) gnt_o[win_idx] = gnt_i;
    end

    assign hs        = win_valid & gnt_i;
    assign rel_match = release_i && (release_id_i == owner_id);
    assign tmo_hit   = (tcnt == TW'(LOCK_TIMEOUT - 1));
    assign rr_next   = (win_idx == PW'(N_MASTER - 1)) ? '0 : win_idx + PW'(1);

    // A re-arming owner handshake beats a coincident release or timeout; release beats timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            owner_id  <= '0;
            tcnt      <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            if (fsm == IDLE) begin
                if (hs) begin
                    rr_ptr <= rr_next;
                    if (excl_i[win_idx]) begin
                        fsm      <= LOCKED;
                        owner    <= win_idx;
                        owner_id <= id_arr[win_idx];
                        tcnt     <= '0;
                    end
                end
            end else begin
                if (hs && excl_i[owner]) begin
                    owner_id <= id_arr[owner];
                    tcnt     <= '0;
                end else if (rel_match) begin
                    fsm  <= IDLE;
                    tcnt <= '0;
                end else if (tmo_hit) begin
                    fsm       <= IDLE;
                    tcnt      <= '0;
                    timeout_o <= 1'b1;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

    assign locked_o     = (fsm == LOCKED);
    assign lock_owner_o = owner;

endmodule

// File: tb/tb_axi_excl_rr_arbiter.sv
// Scoreboard bench for axi_excl_rr_arbiter: expected grants are queued as stimulus is issued
// and a negedge monitor pops one per downstream handshake.
`timescale 1ns/1ps
module tb_axi_excl_rr_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int IW  = 4;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  excl;
    logic [N*AW-1:0] aux_bus;
    logic [N*IW-1:0] id_bus;
    logic [N-1:0]  gnt_o;
    logic          req_o;
    logic [AW-1:0] aux_o;
    logic [IW-1:0] id_o;
    logic          gnt_in;
    logic          rel;
    logic [IW-1:0] rel_id;
    logic          locked_o;
    logic [1:0]    lock_owner_o;
    logic          timeout_o;

    logic [IW-1:0] ids [N];

    typedef struct {
        logic [N-1:0]  gnt;
        logic [IW-1:0] id;
        logic [AW-1:0] aux;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign id_bus = {ids[3], ids[2], ids[1], ids[0]};
    for (genvar g = 0; g < N; g++) begin : g_aux
        assign aux_bus[g*AW +: AW] = 32'hA000_0000 + g;
    end

    axi_excl_rr_arbiter #(
        .N_MASTER(N), .AUX_WIDTH(AW), .ID_WIDTH(IW), .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .excl_i(excl),
        .aux_i(aux_bus), .id_i(id_bus), .gnt_o(gnt_o), .req_o(req_o),
        .aux_o(aux_o), .id_o(id_o), .gnt_i(gnt_in), .release_i(rel),
        .release_id_i(rel_id), .locked_o(locked_o),
        .lock_owner_o(lock_owner_o), .timeout_o(timeout_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input int k, input logic [IW-1:0] idv);
        exp_t e;
        e.gnt = N'(1) << k;
        e.id  = idv;
        e.aux = 32'hA000_0000 + k;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] e, input logic g,
                                 input logic rl, input logic [IW-1:0] rid);
        req    = r;
        excl   = e;
        gnt_in = g;
        rel    = rl;
        rel_id = rid;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every downstream handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && req_o && gnt_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_grant: got gnt=%b id=%h with nothing expected", gnt_o, id_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (gnt_o !== e.gnt || id_o !== e.id || aux_o !== e.aux) begin
                    errors++;
                    $display("[TB] FAIL grant: got gnt=%b id=%h aux=%h expected gnt=%b id=%h aux=%h",
                             gnt_o, id_o, aux_o, e.gnt, e.id, e.aux);
                end
            end
        end
    end

    initial begin
        ids[0] = 4'h1; ids[1] = 4'h2; ids[2] = 4'h3; ids[3] = 4'h4;
        rst_n = 1'b0;
        req = '0; excl = '0; gnt_in = 1'b0; rel = 1'b0; rel_id = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_locked", 32'(locked_o), 0);
        checkOutput("reset_owner", 32'(lock_owner_o), 0);
        checkOutput("reset_timeout", 32'(timeout_o), 0);
        checkOutput("reset_req", 32'(req_o), 0);
        rst_n = 1'b1;
        tick();

        // Round-robin rotation over all four masters
        for (int i = 0; i < 5; i++) begin
            pushExpect(i % 4, ids[i % 4]);
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 4'h0);
            tick();
        end

        // Wrap and skip: grant master 2 to set rr_ptr=3, then 0101 gives 0 then 2
        pushExpect(2, ids[2]);
        applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0, 4'h0);
        tick();
        pushExpect(0, ids[0]);
        applyStimulus(4'b0101, 4'b0000, 1'b1, 1'b0, 4'h0);
        tick();
        pushExpect(2, ids[2]);
        applyStimulus(4'b0101, 4'b0000, 1'b1, 1'b0, 4'h0);
        tick();

        // Backpressure with rr_ptr=3: master 0 presented but not granted
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0, 4'h0);
            checkOutput("bp_req", 32'(req_o), 1);
            checkOutput("bp_gnt", 32'(gnt_o), 0);
            checkOutput("bp_aux", aux_o, 32'hA000_0000);
            tick();
        end
        pushExpect(0, ids[0]);
        applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0, 4'h0);
        tick();

        // Lock by master 2 with id 9, release by matching id only
        ids[2] = 4'h9;
        pushExpect(2, 4'h9);
        applyStimulus(4'b0100, 4'b0100, 1'b1, 1'b0, 4'h0);
        tick();
        applyStimulus(4'b1011, 4'b0000, 1'b1, 1'b0, 4'h0);
        checkOutput("lock_locked", 32'(locked_o), 1);
        checkOutput("lock_owner", 32'(lock_owner_o), 2);
        checkOutput("lock_masked_req", 32'(req_o), 0);
        checkOutput("lock_masked_gnt", 32'(gnt_o), 0);
        tick();
        applyStimulus(4'b1011, 4'b0000, 1'b1, 1'b1, 4'h5);
        tick();
        checkOutput("wrong_id_still_locked", 32'(locked_o), 1);
        applyStimulus(4'b1011, 4'b0000, 1'b1, 1'b1, 4'h9);
        tick();
        pushExpect(3, ids[3]);
        applyStimulus(4'b1011, 4'b0000, 1'b1, 1'b0, 4'h0);
        checkOutput("released_unlocked", 32'(locked_o), 0);
        tick();

        // Timeout: master 1 locks (rr_ptr=0), nobody releases
        pushExpect(1, ids[1]);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0, 4'h0);
        tick();
        for (int i = 0; i < TMO; i++) begin
            applyStimulus(4'b1101, 4'b0000, 1'b1, 1'b0, 4'h0);
            checkOutput("tmo_locked", 32'(locked_o), 1);
            checkOutput("tmo_no_pulse_yet", 32'(timeout_o), 0);
            checkOutput("tmo_masked_req", 32'(req_o), 0);
            tick();
        end
        pushExpect(2, ids[2]);
        applyStimulus(4'b1101, 4'b0000, 1'b1, 1'b0, 4'h0);
        checkOutput("tmo_unlocked", 32'(locked_o), 0);
        checkOutput("tmo_pulse", 32'(timeout_o), 1);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 4'h0);
        checkOutput("tmo_pulse_once", 32'(timeout_o), 0);
        tick();

        // Re-arm coincident with matching release, then release coinciding with timeout
        pushExpect(3, 4'h4);
        applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0, 4'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 4'h0);
            checkOutput("rearm_pre_locked", 32'(locked_o), 1);
            tick();
        end
        ids[3] = 4'h7;
        pushExpect(3, 4'h7);
        applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b1, 4'h4);
        tick();
        for (int i = 0; i < TMO - 1; i++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b1, (i == 0), 4'h4);
            checkOutput("rearm_locked", 32'(locked_o), 1);
            checkOutput("rearm_no_timeout", 32'(timeout_o), 0);
            tick();
        end
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 4'h7);
        checkOutput("rearm_owner", 32'(lock_owner_o), 3);
        tick();
        pushExpect(0, ids[0]);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 4'h0);
        checkOutput("rel_tmo_unlocked", 32'(locked_o), 0);
        checkOutput("rel_tmo_no_pulse", 32'(timeout_o), 0);
        tick();

        // Reset while locked: unlocks asynchronously, rr_ptr back to 0
        pushExpect(2, ids[2]);
        applyStimulus(4'b0100, 4'b0100, 1'b1, 1'b0, 4'h0);
        tick();
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 4'h0);
        checkOutput("pre_reset_locked", 32'(locked_o), 1);
        checkOutput("pre_reset_aux", aux_o, 32'hA000_0002);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_locked", 32'(locked_o), 0);
        checkOutput("async_reset_owner", 32'(lock_owner_o), 0);
        checkOutput("async_reset_aux", aux_o, 32'hA000_0000);
        rst_n = 1'b1;
        tick();
        pushExpect(0, ids[0]);
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 4'h0);
        tick();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0);
        tick();

        checkOutput("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
